load_extend_unit: RTL

//  Data-memory read side of the MIPS datapath: accepts a load request (LW/LH/LHU/LB/LBU),

---
 rtl/load_extend_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/load_extend_unit.sv
// Data-memory load unit: issues a word-aligned req/ack read, then extracts and
// zero/sign-extends the addressed byte or halfword lane for register writeback.
module load_extend_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  LoadType,
  input  logic [31:0] Address,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemRdata,
  output logic [31:0] Result,
  output logic        Done,
  output logic        Busy,
  output logic        Error
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_t;

  state_t      state_q;
  logic [2:0]  type_q;
  logic [1:0]  off_q;
  logic        bad_q;
  logic [7:0]  timer_q;
  logic        memreq_q;
  logic [31:0] memaddr_q;
  logic [31:0] result_q;
  logic        done_q;
  logic        error_q;

  logic        legal_d;
  logic        timeout_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] ext_d;

  always_comb begin
    legal_d = 1'b1;
    case (LoadType)
      LT_LW:          legal_d = (Address[1:0] == 2'b00);
      LT_LH, LT_LHU:  legal_d = ~Address[0];
      LT_LB, LT_LBU:  legal_d = 1'b1;
      default:        legal_d = 1'b0;
    endcase
  end

  // Abort on the wait cycle where the incremented timer would reach TIMEOUT-1,
  // so MemReq (REQ cycle plus WAIT cycles) is high for TIMEOUT cycles in total.
  assign timeout_d = ((32'(timer_q) + 32'd2) >= TIMEOUT);

  always_comb begin
    byte_d = '0;
    case (off_q)
      2'd0: byte_d = MemRdata[31:24];
      2'd1: byte_d = MemRdata[23:16];
      2'd2: byte_d = MemRdata[15:8];
      default: byte_d = MemRdata[7:0];
    endcase
    half_d = off_q[1] ? MemRdata[15:0] : MemRdata[31:16];
    ext_d  = '0;
    case (type_q)
      LT_LW:   ext_d = MemRdata;
      LT_LH:   ext_d = {{16{half_d[15]}}, half_d};
      LT_LHU:  ext_d = {16'h0000, half_d};
      LT_LB:   ext_d = {{24{byte_d[7]}}, byte_d};
      LT_LBU:  ext_d = {24'h000000, byte_d};
      default: ext_d = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      type_q    <= '0;
      off_q     <= '0;
      bad_q     <= 1'b0;
      timer_q   <= '0;
      memreq_q  <= 1'b0;
      memaddr_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            type_q  <= LoadType;
            off_q   <= Address[1:0];
            bad_q   <= ~legal_d;
            state_q <= S_REQ;
            if (legal_d) begin
              memreq_q  <= 1'b1;
              memaddr_q <= {Address[31:2], 2'b00};
            end
          end
        end
        // An illegal request spends this cycle with MemReq low, giving the
        // two-cycle error latency without touching memory.
        S_REQ: begin
          timer_q <= '0;
          if (bad_q) begin
            result_q <= '0;
            done_q   <= 1'b1;
            error_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (MemAck) begin
            result_q <= ext_d;
            memreq_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (timeout_d) begin
            result_q <= '0;
            memreq_q <= 1'b0;
            done_q   <= 1'b1;
            error_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign MemReq  = memreq_q;
  assign MemAddr = memaddr_q;
  assign Result  = result_q;
  assign Done    = done_q;
  assign Error   = error_q;
  assign Busy    = (state_q != S_IDLE);

endmodule
